// File: rtl/expr_arbiter.sv
// ============================================================================
// expr_arbiter
//
// Purpose:
//   Two requesters stream ASCII characters that form small arithmetic
//   expressions ("1+2*3;"). One requester at a time is granted the
//   recognizer. It keeps ownership until its terminator character has been
//   accepted. The block then presents a verdict: well-formed or not, who sent
//   it, and how many characters it had. The verdict is held until the
//   consumer takes it.
//
//   A well-formed expression is a set of single digits separated by single
//   '+' or '*' operators. It must contain at least one digit and no more than
//   MAXLEN characters, not counting the terminator.
//
// Parameters:
//   TERM    terminator character that closes an expression (default ';')
//   MAXLEN  maximum expression length excluding TERM (legal range 1..62)
//
// Ports:
//   clk         rising-edge clock
//   clr_n       asynchronous active-low reset
//   req0_valid  requester 0 presents a character
//   req0_char   requester 0 character
//   req0_ready  requester 0 character accepted when valid && ready
//   req1_valid  requester 1 presents a character
//   req1_char   requester 1 character
//   req1_ready  requester 1 character accepted when valid && ready
//   res_valid   verdict available
//   res_ready   consumer takes the verdict when res_valid && res_ready
//   res_ok      1 = expression well-formed
//   res_id      requester that owned the expression
//   res_len     accepted characters excluding TERM, saturating at MAXLEN+1
//   busy        control FSM is not idle
// ============================================================================
module expr_arbiter #(
    parameter logic [7:0] TERM   = 8'h3B,
    parameter int         MAXLEN = 16
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_ok,
    output logic       res_id,
    output logic [5:0] res_len,
    output logic       busy
);

    // Control FSM: waiting for a requester, streaming one expression, holding
    // the verdict for the consumer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    // Expression recognizer: START before the first character, NUM after a
    // digit, OP after an operator, ERR once anything illegal has been seen.
    typedef enum logic [1:0] {
        START = 2'd0,
        NUM   = 2'd1,
        OP    = 2'd2,
        ERR   = 2'd3
    } rec_state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT = 2'd0,
        CLS_OP    = 2'd1,
        CLS_OTHER = 2'd2,
        CLS_TERM  = 2'd3
    } char_class_t;

    // The length counter stops one past MAXLEN. Any value above MAXLEN
    // already means "too long", so the counter never needs to grow further.
    localparam logic [5:0] LEN_MAX = 6'(MAXLEN);
    localparam logic [5:0] LEN_SAT = 6'(MAXLEN + 1);

    ctrl_state_t ctrlState_q, ctrlState_d;
    rec_state_t  recState_q, recState_d;
    logic [5:0]  len_q, len_d;
    logic        ownerId_q, ownerId_d;
    logic        lastId_q, lastId_d;
    logic        ready0_q, ready0_d;
    logic        ready1_q, ready1_d;
    logic        resValid_q, resValid_d;
    logic        resOk_q, resOk_d;
    logic        resId_q, resId_d;
    logic [5:0]  resLen_q, resLen_d;
    logic        busy_q, busy_d;

    logic        ownerValid;
    logic        ownerReady;
    logic [7:0]  ownerChar;
    logic        accept;
    char_class_t ownerClass;

    function automatic char_class_t classify(input logic [7:0] c);
        char_class_t cls;
        if (c == TERM) begin
            cls = CLS_TERM;
        end else if ((c >= 8'h30) && (c <= 8'h39)) begin
            cls = CLS_DIGIT;
        end else if ((c == 8'h2B) || (c == 8'h2A)) begin
            cls = CLS_OP;
        end else begin
            cls = CLS_OTHER;
        end
        return cls;
    endfunction

    // A digit must follow START or an operator. An operator must follow a
    // digit. Anything else falls into ERR, and ERR never leaves.
    function automatic rec_state_t recStep(input rec_state_t s, input char_class_t c);
        rec_state_t n;
        n = ERR;
        case (s)
            START:   n = (c == CLS_DIGIT) ? NUM : ERR;
            NUM:     n = (c == CLS_OP)    ? OP  : ERR;
            OP:      n = (c == CLS_DIGIT) ? NUM : ERR;
            default: n = ERR;
        endcase
        return n;
    endfunction

    // Steer the granted requester's handshake into the shared recognizer.
    // Acceptance uses the registered ready. This keeps the handshake
    // identical to what the requester saw on its ready output.
    always_comb begin
        ownerValid = ownerId_q ? req1_valid : req0_valid;
        ownerChar  = ownerId_q ? req1_char  : req0_char;
        ownerReady = ownerId_q ? ready1_q   : ready0_q;
        accept     = (ctrlState_q == RUN) && ownerReady && ownerValid;
        ownerClass = classify(ownerChar);
    end

    // Next-state logic for the control FSM, the recognizer, and the
    // registered outputs. Every output is computed from the next state, so the
    // output registers line up with the state they describe.
    always_comb begin
        ctrlState_d = ctrlState_q;
        recState_d  = recState_q;
        len_d       = len_q;
        ownerId_d   = ownerId_q;
        lastId_d    = lastId_q;
        resValid_d  = resValid_q;
        resOk_d     = resOk_q;
        resId_d     = resId_q;
        resLen_d    = resLen_q;

        case (ctrlState_q)
            IDLE: begin
                // On a tie, the requester not served last gets the grant.
                // After reset lastId is 1, so requester 0 wins the first tie.
                if (req0_valid || req1_valid) begin
                    ctrlState_d = RUN;
                    recState_d  = START;
                    len_d       = 6'd0;
                    if (req0_valid && req1_valid) begin
                        ownerId_d = ~lastId_q;
                    end else begin
                        ownerId_d = req1_valid;
                    end
                end
            end

            RUN: begin
                if (accept) begin
                    if (ownerClass == CLS_TERM) begin
                        ctrlState_d = DONE;
                        resValid_d  = 1'b1;
                        resOk_d     = (recState_q == NUM) && (len_q <= LEN_MAX);
                        resId_d     = ownerId_q;
                        resLen_d    = len_q;
                    end else begin
                        recState_d = recStep(recState_q, ownerClass);
                        if (len_q != LEN_SAT) begin
                            len_d = len_q + 6'd1;
                        end
                    end
                end
            end

            DONE: begin
                if (res_ready) begin
                    ctrlState_d = IDLE;
                    resValid_d  = 1'b0;
                    lastId_d    = resId_q;
                end
            end

            default: begin
                ctrlState_d = IDLE;
                resValid_d  = 1'b0;
            end
        endcase

        ready0_d = (ctrlState_d == RUN) && !ownerId_d;
        ready1_d = (ctrlState_d == RUN) &&  ownerId_d;
        busy_d   = (ctrlState_d != IDLE);
    end

    // State and output registers. Reset drops any partial expression or
    // pending verdict immediately.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ctrlState_q <= IDLE;
            recState_q  <= START;
            len_q       <= 6'd0;
            ownerId_q   <= 1'b0;
            lastId_q    <= 1'b1;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            resValid_q  <= 1'b0;
            resOk_q     <= 1'b0;
            resId_q     <= 1'b0;
            resLen_q    <= 6'd0;
            busy_q      <= 1'b0;
        end else begin
            ctrlState_q <= ctrlState_d;
            recState_q  <= recState_d;
            len_q       <= len_d;
            ownerId_q   <= ownerId_d;
            lastId_q    <= lastId_d;
            ready0_q    <= ready0_d;
            ready1_q    <= ready1_d;
            resValid_q  <= resValid_d;
            resOk_q     <= resOk_d;
            resId_q     <= resId_d;
            resLen_q    <= resLen_d;
            busy_q      <= busy_d;
        end
    end

    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign res_valid  = resValid_q;
    assign res_ok     = resOk_q;
    assign res_id     = resId_q;
    assign res_len    = resLen_q;
    assign busy       = busy_q;

endmodule
